// File: rtl/rgb_to_yuv_unit_if.sv
// Bus between the RGB-to-YUV engine and its surroundings.
//
// start      : begin (or restart) a frame conversion from pixel 0
// mem_raddr  : input-memory read address (sample plane R/G/B)
// mem_rdata  : input-memory read data, valid one cycle after mem_raddr
// mem_waddr  : output-memory write address (plane Y/U/V)
// mem_wdata  : output-memory write data
// mem_wren   : output-memory write enable, write occurs on the rising edge
// busy       : engine is not idle
// done       : one-cycle pulse at the end of a frame
//
// master : the side that launches frames and owns both memories
// slave  : the conversion engine
interface rgb_to_yuv_unit_if #(
    parameter int ADDR_W = 16
);
    logic              start;
    logic [ADDR_W-1:0] mem_raddr;
    logic [7:0]        mem_rdata;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;
    logic              mem_wren;
    logic              busy;
    logic              done;

    modport master (
        output start,
        output mem_rdata,
        input  mem_raddr,
        input  mem_waddr,
        input  mem_wdata,
        input  mem_wren,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  mem_rdata,
        output mem_raddr,
        output mem_waddr,
        output mem_wdata,
        output mem_wren,
        output busy,
        output done
    );
endinterface

// File: rtl/rgb_to_yuv_unit.sv
// Sequential RGB -> YUV (BT.601, Q8) frame converter.
//
// Reads one pixel as three samples from planar R/G/B input memory
// (synchronous read, one cycle latency), computes Y/U/V and writes the
// three results to planar Y/U/V output memory. One start pulse converts
// the whole frame; done pulses for one cycle at the end.
//
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : rgb_to_yuv_unit_if.slave (start, memory ports, busy, done)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start
// RD_R  | present R_BASE+idx on the read port
// RD_G  | present G_BASE+idx, R sample returns and is captured
// RD_B  | present B_BASE+idx, G sample returns and is captured
// CAP_B | no read, B sample returns and is captured
// CALC  | compute Y/U/V from captured R/G/B, register results
// WR_Y  | write Y to Y_BASE+idx
// WR_U  | write U to U_BASE+idx
// WR_V  | write V to V_BASE+idx, then next pixel or DONE
// DONE  | frame complete, done pulse
module rgb_to_yuv_unit #(
    parameter int ADDR_W   = 16,
    parameter int N_PIXELS = 4,
    parameter int R_BASE   = 0,
    parameter int G_BASE   = N_PIXELS,
    parameter int B_BASE   = 2 * N_PIXELS,
    parameter int Y_BASE   = 0,
    parameter int U_BASE   = N_PIXELS,
    parameter int V_BASE   = 2 * N_PIXELS
) (
    input  logic              clk,
    input  logic              rst,
    rgb_to_yuv_unit_if.slave  bus
);

    typedef enum logic [3:0] {
        IDLE,
        RD_R,
        RD_G,
        RD_B,
        CAP_B,
        CALC,
        WR_Y,
        WR_U,
        WR_V,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_nxt;
    logic              last_px;

    logic [7:0] r_q;
    logic [7:0] g_q;
    logic [7:0] b_q;
    logic [7:0] y_q;
    logic [7:0] u_q;
    logic [7:0] v_q;

    logic signed [17:0] r_s;
    logic signed [17:0] g_s;
    logic signed [17:0] b_s;
    logic signed [17:0] acc_y;
    logic signed [17:0] acc_u;
    logic signed [17:0] acc_v;

    logic [ADDR_W-1:0] raddr;
    logic [ADDR_W-1:0] waddr;
    logic [7:0]        wdata;
    logic              wren;

    assign last_px = (idx == ADDR_W'(N_PIXELS - 1));

    // ------------------------------------------------------------------
    // Next-state logic. start overrides every state, including DONE, so
    // a restart never has to pass through IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (bus.start) begin
            state_nxt = RD_R;
            idx_nxt   = '0;
        end else begin
            case (state)
                IDLE:  state_nxt = IDLE;
                RD_R:  state_nxt = RD_G;
                RD_G:  state_nxt = RD_B;
                RD_B:  state_nxt = CAP_B;
                CAP_B: state_nxt = CALC;
                CALC:  state_nxt = WR_Y;
                WR_Y:  state_nxt = WR_U;
                WR_U:  state_nxt = WR_V;
                WR_V: begin
                    if (last_px) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = RD_R;
                        idx_nxt   = idx + ADDR_W'(1);
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Arithmetic. Samples are zero-extended into 18-bit signed operands.
    // The +32768 offset on U/V keeps the accumulators non-negative for
    // every 8-bit input, the clamp still guards both ends.
    // ------------------------------------------------------------------
    assign r_s = signed'({10'd0, r_q});
    assign g_s = signed'({10'd0, g_q});
    assign b_s = signed'({10'd0, b_q});

    assign acc_y =   (18'sd77  * r_s) + (18'sd150 * g_s) + (18'sd29  * b_s)
                   + 18'sd128;
    assign acc_u = - (18'sd43  * r_s) - (18'sd85  * g_s) + (18'sd128 * b_s)
                   + 18'sd32896;
    assign acc_v =   (18'sd128 * r_s) - (18'sd107 * g_s) - (18'sd21  * b_s)
                   + 18'sd32896;

    // acc >>> 8 keeps bits [17:8]; that 10-bit signed value is clamped.
    function automatic logic [7:0] clamp8(input logic signed [17:0] acc);
        logic signed [9:0] q;
        q = acc[17:8];
        if (q < 10'sd0) begin
            return 8'd0;
        end else if (q > 10'sd255) begin
            return 8'd255;
        end else begin
            return q[7:0];
        end
    endfunction

    // Each sample arrives one cycle after its address, hence the capture
    // points sit one state behind the corresponding read state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
            g_q <= '0;
            b_q <= '0;
            y_q <= '0;
            u_q <= '0;
            v_q <= '0;
        end else begin
            case (state)
                RD_G:  r_q <= bus.mem_rdata;
                RD_B:  g_q <= bus.mem_rdata;
                CAP_B: b_q <= bus.mem_rdata;
                CALC: begin
                    y_q <= clamp8(acc_y);
                    u_q <= clamp8(acc_u);
                    v_q <= clamp8(acc_v);
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Memory-port outputs decode straight from the state register, so an
    // asynchronous reset drops them without waiting for a clock edge.
    // ------------------------------------------------------------------
    always_comb begin
        raddr = '0;
        waddr = '0;
        wdata = '0;
        wren  = 1'b0;
        case (state)
            RD_R: raddr = ADDR_W'(R_BASE) + idx;
            RD_G: raddr = ADDR_W'(G_BASE) + idx;
            RD_B: raddr = ADDR_W'(B_BASE) + idx;
            WR_Y: begin
                waddr = ADDR_W'(Y_BASE) + idx;
                wdata = y_q;
                wren  = 1'b1;
            end
            WR_U: begin
                waddr = ADDR_W'(U_BASE) + idx;
                wdata = u_q;
                wren  = 1'b1;
            end
            WR_V: begin
                waddr = ADDR_W'(V_BASE) + idx;
                wdata = v_q;
                wren  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.mem_raddr = raddr;
    assign bus.mem_waddr = waddr;
    assign bus.mem_wdata = wdata;
    assign bus.mem_wren  = wren;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);

endmodule

// File: tb/tb_rgb_to_yuv_unit.sv
// Self-checking bench for rgb_to_yuv_unit (N_PIXELS=4, default bases).
// Expected writes are queued when a frame is launched and popped as the
// engine writes; the port timing is checked every cycle of every frame.
module tb_rgb_to_yuv_unit;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int RB = 0;
    localparam int GB = N;
    localparam int BB = 2 * N;
    localparam int YB = 0;
    localparam int UB = N;
    localparam int VB = 2 * N;
    localparam int LAST_C = 8 * N + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rgb_to_yuv_unit_if #(.ADDR_W(AW)) bus ();

    rgb_to_yuv_unit #(
        .ADDR_W   (AW),
        .N_PIXELS (N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] in_mem  [0:63];
    logic [7:0] out_mem [0:63];
    int         wren_cnt = 0;
    int         done_cnt = 0;

    always @(posedge clk) begin
        bus.mem_rdata <= in_mem[bus.mem_raddr[5:0]];
        if (bus.mem_wren) out_mem[bus.mem_waddr[5:0]] <= bus.mem_wdata;
        if (bus.mem_wren) wren_cnt <= wren_cnt + 1;
        if (bus.done)     done_cnt <= done_cnt + 1;
    end

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  pr [N];
    int  pg [N];
    int  pb [N];
    int  n_err = 0;
    int  n_chk = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic int clamp(input int acc);
        int s;
        s = acc >>> 8;
        if (s < 0)   s = 0;
        if (s > 255) s = 255;
        return s;
    endfunction

    // Load the pixel arrays into input memory and queue expected writes.
    task automatic push_frame();
        for (int p = 0; p < N; p++) begin
            wr_t w;
            in_mem[RB + p] = 8'(pr[p]);
            in_mem[GB + p] = 8'(pg[p]);
            in_mem[BB + p] = 8'(pb[p]);
            w.addr = YB + p;
            w.data = clamp(77 * pr[p] + 150 * pg[p] + 29 * pb[p] + 128);
            exp_q.push_back(w);
            w.addr = UB + p;
            w.data = clamp(-43 * pr[p] - 85 * pg[p] + 128 * pb[p] + 32896);
            exp_q.push_back(w);
            w.addr = VB + p;
            w.data = clamp(128 * pr[p] - 107 * pg[p] - 21 * pb[p] + 32896);
            exp_q.push_back(w);
        end
    endtask

    // Called at a negedge; leaves the bench mid-cycle 1 of the frame.
    task automatic kick();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Checks cycles c0..c1 of a frame (bench is mid-cycle c0 on entry).
    // start is raised during cycle restart_at.
    task automatic run_cycles(input int c0, input int c1, input int restart_at);
        for (int c = c0; c <= c1; c++) begin
            int   p;
            int   ph;
            int   er;
            logic ewr;
            p   = (c - 1) / 8;
            ph  = (c - 1) % 8;
            er  = 0;
            ewr = 1'b0;
            if (c <= 8 * N) begin
                case (ph)
                    0: er = RB + p;
                    1: er = GB + p;
                    2: er = BB + p;
                    5, 6, 7: ewr = 1'b1;
                    default: ;
                endcase
            end
            chk("raddr", 32'(bus.mem_raddr), 32'(er));
            chk("wren",  32'(bus.mem_wren),  32'(ewr));
            chk("busy",  32'(bus.busy),      32'd1);
            chk("done",  32'(bus.done),      32'(c == LAST_C));
            if (ewr) begin
                chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    wr_t w;
                    w = exp_q.pop_front();
                    chk("waddr", 32'(bus.mem_waddr), 32'(w.addr));
                    chk("wdata", 32'(bus.mem_wdata), 32'(w.data));
                end
            end else begin
                chk("waddr_idle", 32'(bus.mem_waddr), 32'd0);
                chk("wdata_idle", 32'(bus.mem_wdata), 32'd0);
            end
            bus.start = (c == restart_at);
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy),     32'd0);
        chk({tag, "_done"}, 32'(bus.done),     32'd0);
        chk({tag, "_wren"}, 32'(bus.mem_wren), 32'd0);
    endtask

    initial begin
        int w0;
        int d0;

        rst       = 1'b1;
        bus.start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            in_mem[i]  = 8'd0;
            out_mem[i] = 8'd0;
        end
        repeat (2) @(negedge clk);

        chk("rst_raddr", 32'(bus.mem_raddr), 32'd0);
        chk("rst_waddr", 32'(bus.mem_waddr), 32'd0);
        chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rst_wren",  32'(bus.mem_wren),  32'd0);
        chk("rst_busy",  32'(bus.busy),      32'd0);
        chk("rst_done",  32'(bus.done),      32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("hold");

        // Frame 1: black, white, red, green
        pr = '{0, 255, 255, 0};
        pg = '{0, 255, 0, 255};
        pb = '{0, 255, 0, 0};
        push_frame();
        w0 = wren_cnt;
        kick();
        run_cycles(1, LAST_C, -1);
        chk_idle("f1_end");
        chk("f1_wren_count", 32'(wren_cnt - w0), 32'(3 * N));
        chk("f1_sb_empty",   32'(exp_q.size()),  32'd0);
        chk("black_y", 32'(out_mem[YB + 0]), 32'd0);
        chk("black_u", 32'(out_mem[UB + 0]), 32'd128);
        chk("black_v", 32'(out_mem[VB + 0]), 32'd128);
        chk("white_y", 32'(out_mem[YB + 1]), 32'd255);
        chk("white_u", 32'(out_mem[UB + 1]), 32'd128);
        chk("white_v", 32'(out_mem[VB + 1]), 32'd128);
        chk("red_y",   32'(out_mem[YB + 2]), 32'd77);
        chk("red_u",   32'(out_mem[UB + 2]), 32'd85);
        chk("red_v",   32'(out_mem[VB + 2]), 32'd255);
        chk("green_y", 32'(out_mem[YB + 3]), 32'd149);
        chk("green_u", 32'(out_mem[UB + 3]), 32'd43);
        chk("green_v", 32'(out_mem[VB + 3]), 32'd21);

        // Frame 2: blue plus random pixels, restarted in pixel 2 WR_U
        pr[0] = 0; pg[0] = 0; pb[0] = 255;
        for (int p = 1; p < N; p++) begin
            pr[p] = int'($urandom_range(0, 255));
            pg[p] = int'($urandom_range(0, 255));
            pb[p] = int'($urandom_range(0, 255));
        end
        push_frame();
        kick();
        run_cycles(1, 8 * 2 + 7, 8 * 2 + 7);
        exp_q.delete();
        push_frame();
        run_cycles(1, LAST_C, -1);
        chk_idle("f2_end");
        chk("blue_y", 32'(out_mem[YB + 0]), 32'd29);
        chk("blue_u", 32'(out_mem[UB + 0]), 32'd255);
        chk("blue_v", 32'(out_mem[VB + 0]), 32'd107);

        // Frame 3: start collides with DONE, second frame follows directly
        for (int p = 0; p < N; p++) begin
            pr[p] = int'($urandom_range(0, 255));
            pg[p] = int'($urandom_range(0, 255));
            pb[p] = int'($urandom_range(0, 255));
        end
        push_frame();
        d0 = done_cnt;
        kick();
        run_cycles(1, LAST_C, LAST_C);
        push_frame();
        run_cycles(1, LAST_C, -1);
        chk_idle("f3_end");
        chk("f3_done_count", 32'(done_cnt - d0), 32'd2);

        // Frame 4: asynchronous reset during pixel 1 CALC
        push_frame();
        kick();
        run_cycles(1, 12, -1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy",  32'(bus.busy),      32'd0);
        chk("arst_wren",  32'(bus.mem_wren),  32'd0);
        chk("arst_done",  32'(bus.done),      32'd0);
        chk("arst_raddr", 32'(bus.mem_raddr), 32'd0);
        chk("arst_waddr", 32'(bus.mem_waddr), 32'd0);
        exp_q.delete();
        w0 = wren_cnt;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk_idle("post_rst");
        chk("post_rst_no_writes", 32'(wren_cnt - w0), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rgb_to_yuv_unit.md
# rgb_to_yuv_unit

Converts a frame of 8-bit RGB pixels stored as three planes (R, G, B) into three YUV planes (BT.601, Q8 fixed point) with one sequential engine. It is the encode-side counterpart of the YUV-to-RGB path. It reads one sample per cycle from a synchronous-read pixel memory, computes Y/U/V for one pixel, and writes the three results to an output memory. The whole frame is processed after a single `start` pulse and finishes with a one-cycle `done`.

## Interface
- `ADDR_W`, 16, address width of both memory ports
- `N_PIXELS`, 4, pixels per frame (≥1)
- `R_BASE`, `G_BASE`, `B_BASE`, 0 / N_PIXELS / 2·N_PIXELS, input plane base addresses
- `Y_BASE`, `U_BASE`, `V_BASE`, 0 / N_PIXELS / 2·N_PIXELS, output plane base addresses
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin (or restart) conversion from pixel 0
- `mem_raddr`  out  ADDR_W  input-memory read address
- `mem_rdata`  in  8  read data, valid one cycle after the address is presented
- `mem_waddr`  out  ADDR_W  output-memory write address
- `mem_wdata`  out  8  write data
- `mem_wren`  out  1  write enable; the write happens on the rising edge while high
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when the frame is complete

## Operation
- **Reset values** (`rst` high): state = IDLE, idx = 0, R/G/B/Y/U/V registers = 0. All outputs are 0: `mem_raddr`, `mem_waddr`, `mem_wdata`, `mem_wren`, `busy`, `done`.
- **States:** IDLE, RD_R, RD_G, RD_B, CAP_B, CALC, WR_Y, WR_U, WR_V, DONE.
- **Transitions**
  - `start` = 1 in any state → RD_R with idx = 0. Restart is allowed mid-frame, and partial output already written is left as is.
  - Otherwise: IDLE holds.
  - RD_R → RD_G → RD_B → CAP_B → CALC → WR_Y → WR_U → WR_V.
  - WR_V → DONE if idx = N_PIXELS−1; else RD_R with idx+1.
  - DONE → IDLE.
- **Read addresses:** RD_R presents `R_BASE+idx`, RD_G presents `G_BASE+idx`, RD_B presents `B_BASE+idx`. In all other states `mem_raddr` = 0.
- **Sample capture:** R is captured at the end of RD_G, G at the end of RD_B, B at the end of CAP_B, each from `mem_rdata`.
- **Arithmetic (CALC):** 18-bit signed, results registered at the end of CALC.
  - `accY = 77R + 150G + 29B + 128`
  - `accU = −43R − 85G + 128B + 32768 + 128`
  - `accV = 128R − 107G − 21B + 32768 + 128`
  - Each result = `acc >>> 8`, then clamped to [0, 255].
- **Writes:**
  - WR_Y: `mem_waddr` = `Y_BASE+idx`, `mem_wdata` = Y, `mem_wren` = 1.
  - WR_U and WR_V: same pattern with `U_BASE`/U and `V_BASE`/V.
  - Outside the WR states, `mem_wren` = 0 and `mem_waddr`/`mem_wdata` = 0.
- `done` = 1 only in DONE.
- idx never exceeds N_PIXELS−1; there is no wrap-around.

## Timing
- Edge 0 samples `start`. Pixel p occupies cycles 8p+1 … 8p+8, in the order RD_R, RD_G, RD_B, CAP_B, CALC, WR_Y, WR_U, WR_V.
- `done` is high in cycle 8·N_PIXELS+1. `busy` is high in cycles 1 … 8·N_PIXELS+1. The state is IDLE from cycle 8·N_PIXELS+2.
- Memory read latency is exactly 1 cycle, and no read is issued in consecutive pixels' CALC or WR states.
- `start` in the same cycle as DONE: restart wins, so the next state is RD_R, but `done` is still high that cycle.
- `rst` asserted mid-frame forces IDLE immediately (asynchronously). No further writes occur.

## Test plan
- **Single-pixel grey levels:** N_PIXELS=2, pixels (0,0,0) and (255,255,255), then `start` → writes Y/U/V = 0/128/128 and 255/128/128. `done` is high at cycle 17, and exactly 6 `mem_wren` pulses occur.
- **Primaries:**
  - red (255,0,0) → 77/85/255, with V clamped from 256
  - green (0,255,0) → 149/43/21
  - blue (0,0,255) → 29/255/107, with U clamped
- **Address sweep:** N_PIXELS=4 with default bases → reads in order 0,4,8,1,5,9,…; writes in order 0,4,8,1,5,9,…,3,7,11. `mem_raddr` = 0 in all non-read states.
- **Mid-frame restart:** pulse `start` during pixel 2 WR_U → next cycle RD_R with `mem_raddr`=`R_BASE`. `done` comes 8·N_PIXELS+1 cycles after the restart edge.
- **Asynchronous reset:** assert `rst` between clock edges during CALC → `busy`, `mem_wren`, `done` and both addresses drop to 0 before the next edge. After release, the block stays IDLE until `start`.
- **Start/DONE collision:** `start` high in the DONE cycle → `done` is pulsed once, and a second full frame follows without passing through IDLE.
